// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter: two-phase RAM sharing between the 6502 core and the
// VIC-II fetch unit, with BA/AEC-style cycle stealing.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   cpu_ab/do/we       CPU address, write data, write request
//   cpu_di             CPU read data (live in its slot, held otherwise)
//   cpu_ce, cpu_rdy    CPU clock enable, not-held-by-VIC flag
//   vic_ab, vic_bank   VIC address within bank, bank select
//   vic_steal_req      VIC wants both phases
//   vic_di, _valid     latched VIC read data, one-cycle update pulse
//   ba                 bus available (0 = steal pending/active)
//   ram_ab/do/we/di    RAM port
module c64_bus_arbiter #(
  parameter int BA_LEAD = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_ce,
  output logic        cpu_rdy,
  input  logic [13:0] vic_ab,
  input  logic [1:0]  vic_bank,
  input  logic        vic_steal_req,
  output logic [7:0]  vic_di,
  output logic        vic_di_valid,
  output logic        ba,
  output logic [15:0] ram_ab,
  output logic [7:0]  ram_do,
  output logic        ram_we,
  input  logic [7:0]  ram_di
);

  localparam int CW = (BA_LEAD < 2) ? 1 : $clog2(BA_LEAD);
  localparam logic [CW-1:0] LAST = CW'(BA_LEAD - 1);

  typedef enum logic [1:0] {
    IDLE,
    BA_WAIT,
    STEAL
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            phase;
  logic [CW-1:0]   ba_cnt;
  logic [CW-1:0]   ba_cnt_nx;
  logic [7:0]      hold_cpu;
  logic [7:0]      vic_q;
  logic            vic_v;
  logic            vic_own;
  logic            cpu_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= 1'b0;
      state    <= IDLE;
      ba_cnt   <= '0;
      hold_cpu <= 8'h00;
      vic_q    <= 8'h00;
      vic_v    <= 1'b0;
    end else begin
      phase  <= ~phase;
      state  <= state_nx;
      ba_cnt <= ba_cnt_nx;
      vic_v  <= vic_own;
      if (cpu_rd)
        hold_cpu <= ram_di;
      if (vic_own)
        vic_q <= ram_di;
    end
  end

  always_comb begin
    state_nx  = state;
    ba_cnt_nx = ba_cnt;
    ram_ab    = {vic_bank, vic_ab};
    ram_do    = cpu_do;
    ram_we    = 1'b0;
    cpu_ce    = 1'b0;
    ba        = (state == IDLE);
    cpu_rdy   = (state == IDLE);
    vic_own   = ~phase | (state == STEAL);

    // Only the end of a CPU (phase-1) slot moves the FSM, so
    // request changes in phase 0 wait for the next slot edge.
    if (phase) begin
      unique case (state)
        IDLE: begin
          ram_ab = cpu_ab;
          ram_we = cpu_we;
          cpu_ce = 1'b1;
          if (vic_steal_req) begin
            state_nx  = BA_WAIT;
            ba_cnt_nx = '0;
          end
        end
        BA_WAIT: begin
          // Grace slot: writes complete, reads stall.
          ram_ab    = cpu_ab;
          ram_we    = cpu_we;
          cpu_ce    = cpu_we;
          ba_cnt_nx = ba_cnt + 1'b1;
          if (!vic_steal_req)
            state_nx = IDLE;
          else if (ba_cnt == LAST)
            state_nx = STEAL;
        end
        STEAL: begin
          if (!vic_steal_req)
            state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end

    // Nothing reaches RAM or the CPU in a reset cycle.
    if (reset) begin
      ram_we = 1'b0;
      cpu_ce = 1'b0;
    end

    cpu_rd       = cpu_ce & ~cpu_we;
    cpu_di       = cpu_rd ? ram_di : hold_cpu;
    vic_di       = vic_q;
    vic_di_valid = vic_v;
  end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb_c64_bus_arbiter: directed plus random checks of the bus arbiter
// against a slot-level reference model and a behavioural RAM.
module tb_c64_bus_arbiter;

  localparam int BA_LEAD = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_ab = '0;
  logic [7:0]  cpu_do = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_di;
  logic        cpu_ce;
  logic        cpu_rdy;
  logic [13:0] vic_ab = '0;
  logic [1:0]  vic_bank = '0;
  logic        vic_steal_req = 1'b0;
  logic [7:0]  vic_di;
  logic        vic_di_valid;
  logic        ba;
  logic [15:0] ram_ab;
  logic [7:0]  ram_do;
  logic        ram_we;
  logic [7:0]  ram_di;

  c64_bus_arbiter #(.BA_LEAD(BA_LEAD)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_ab       (cpu_ab),
    .cpu_do       (cpu_do),
    .cpu_we       (cpu_we),
    .cpu_di       (cpu_di),
    .cpu_ce       (cpu_ce),
    .cpu_rdy      (cpu_rdy),
    .vic_ab       (vic_ab),
    .vic_bank     (vic_bank),
    .vic_steal_req(vic_steal_req),
    .vic_di       (vic_di),
    .vic_di_valid (vic_di_valid),
    .ba           (ba),
    .ram_ab       (ram_ab),
    .ram_do       (ram_do),
    .ram_we       (ram_we),
    .ram_di       (ram_di)
  );

  always #5 clk = ~clk;

  logic [7:0] mem  [0:65535];
  logic [7:0] rmem [0:65535];
  assign ram_di = mem[ram_ab];

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int we_cnt = 0;

  // Reference model: phase bit and number of grace slots used
  // (-1 = bus free, BA_LEAD = VIC owns both phases).
  bit         m_phase = 1'b0;
  int         m_wait = -1;
  logic [7:0] m_hold = '0;
  logic [7:0] m_vdi = '0;
  bit         m_vv = 1'b0;

  function automatic logic [7:0] init_v(input int i);
    return 8'(i ^ (i >> 8));
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit do_chk);
    bit         vown;
    bit         slot;
    bit         idle;
    logic [15:0] e_ab;
    bit         e_we;
    bit         e_ce;
    logic [7:0] e_di;
    bit         w_en;
    logic [15:0] w_a;
    logic [7:0] w_d;
    @(negedge clk);
    vown = (m_phase == 1'b0) || (m_wait == BA_LEAD);
    slot = m_phase && !vown;
    idle = (m_wait < 0);
    e_ab = vown ? {vic_bank, vic_ab} : cpu_ab;
    e_we = slot && cpu_we && !reset;
    e_ce = slot && (idle || cpu_we) && !reset;
    e_di = (e_ce && !cpu_we) ? rmem[cpu_ab] : m_hold;
    if (do_chk) begin
      chk("ram_ab", ram_ab, e_ab);
      chk("ram_we", {15'd0, ram_we}, {15'd0, e_we});
      if (e_we)
        chk("ram_do", {8'd0, ram_do}, {8'd0, cpu_do});
      chk("cpu_ce", {15'd0, cpu_ce}, {15'd0, e_ce});
      chk("ba", {15'd0, ba}, {15'd0, idle});
      chk("cpu_rdy", {15'd0, cpu_rdy}, {15'd0, idle});
      chk("cpu_di", {8'd0, cpu_di}, {8'd0, e_di});
      chk("vic_di", {8'd0, vic_di}, {8'd0, m_vdi});
      chk("vic_valid", {15'd0, vic_di_valid},
          {15'd0, m_vv});
    end
    w_en = (ram_we === 1'b1);
    w_a = ram_ab;
    w_d = ram_do;
    if (w_en)
      we_cnt++;
    @(posedge clk);
    if (w_en)
      mem[w_a] = w_d;
    if (reset) begin
      m_phase = 1'b0;
      m_wait = -1;
      m_hold = '0;
      m_vdi = '0;
      m_vv = 1'b0;
    end else begin
      if (e_ce && !cpu_we)
        m_hold = rmem[cpu_ab];
      m_vv = vown;
      if (vown)
        m_vdi = rmem[e_ab];
      if (e_we)
        rmem[cpu_ab] = cpu_do;
      if (m_phase) begin
        if (!vic_steal_req)
          m_wait = -1;
        else if (m_wait < BA_LEAD)
          m_wait = m_wait + 1;
      end
      m_phase = !m_phase;
    end
    #1;
  endtask

  task automatic align1();
    if (!m_phase)
      cyc(1);
  endtask

  task automatic set_cpu(input logic [15:0] a,
                         input logic [7:0] d,
                         input logic w);
    cpu_ab = a;
    cpu_do = d;
    cpu_we = w;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = init_v(i);
      rmem[i] = init_v(i);
    end
    mem[16'h0400] = 8'd90;
    rmem[16'h0400] = 8'd90;
    mem[16'h0030] = 8'd71;
    rmem[16'h0030] = 8'd71;

    // Reset and reset-state checks.
    set_cpu(16'h0400, 8'h00, 1'b0);
    vic_ab = 14'h0030;
    reset = 1'b1;
    cyc(0);
    cyc(0);
    reset = 1'b0;
    chk("rst_ba", {15'd0, ba}, 16'd1);
    chk("rst_rdy", {15'd0, cpu_rdy}, 16'd1);
    chk("rst_ce", {15'd0, cpu_ce}, 16'd0);
    chk("rst_we", {15'd0, ram_we}, 16'd0);
    chk("rst_cpu_di", {8'd0, cpu_di}, 16'd0);
    chk("rst_vic_di", {8'd0, vic_di}, 16'd0);
    chk("rst_valid", {15'd0, vic_di_valid}, 16'd0);
    chk("rst_ab", ram_ab, 16'h0030);

    // Interleave: first CPU slot is the second cycle.
    cyc(1);
    chk("first_slot_ce", {15'd0, cpu_ce}, 16'd1);
    chk("first_slot_di", {8'd0, cpu_di}, 16'd90);
    for (int i = 0; i < 8; i++)
      cyc(1);
    chk("il_cpu_hold", {8'd0, cpu_di}, 16'd90);
    chk("il_vic_di", {8'd0, vic_di}, 16'd71);

    // Single CPU write in IDLE.
    align1();
    we_cnt = 0;
    set_cpu(16'h0440, 8'h27, 1'b1);
    cyc(1);
    set_cpu(16'h0400, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1);
    chk("wr_once", 16'(we_cnt), 16'd1);
    chk("wr_mem", {8'd0, mem[16'h0440]}, 16'h0027);

    // Steal with three grace writes.
    align1();
    vic_steal_req = 1'b1;
    cyc(1);
    chk("ba_fall", {15'd0, ba}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      set_cpu(16'(16'h0010 + k), 8'(8'h11 + k), 1'b1);
      cyc(1);
      cyc(1);
    end
    chk("sw_mem0", {8'd0, mem[16'h0010]}, 16'h0011);
    chk("sw_mem1", {8'd0, mem[16'h0011]}, 16'h0012);
    chk("sw_mem2", {8'd0, mem[16'h0012]}, 16'h0013);
    we_cnt = 0;
    set_cpu(16'h0050, 8'hEE, 1'b1);
    vic_ab = 14'h0123;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("st_ab", ram_ab, 16'h0123);
      chk("st_ce", {15'd0, cpu_ce}, 16'd0);
    end
    chk("st_no_wr", 16'(we_cnt), 16'd0);
    chk("st_mem", {8'd0, mem[16'h0050]}, 16'h0050);
    vic_steal_req = 1'b0;
    set_cpu(16'h0400, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1);

    // Steal with a stalled read.
    align1();
    vic_steal_req = 1'b1;
    cyc(1);
    set_cpu(16'h0500, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("sr_ce", {15'd0, cpu_ce}, 16'd0);
      chk("sr_hold", {8'd0, cpu_di}, 16'd90);
    end
    vic_steal_req = 1'b0;
    cyc(1);
    cyc(1);
    cyc(1);
    chk("sr_ce_back", {15'd0, cpu_ce}, 16'd1);
    chk("sr_read", {8'd0, cpu_di}, 16'h0005);

    // Bank mapping.
    if (m_phase)
      cyc(1);
    vic_bank = 2'd2;
    vic_ab = 14'h0035;
    #1;
    chk("bank_ab", ram_ab, 16'h8035);
    cyc(1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_cpu(16'($urandom_range(0, 255)),
              8'($urandom), 1'($urandom));
      vic_ab = 14'($urandom);
      vic_bank = 2'($urandom);
      if ($urandom_range(0, 7) == 0)
        vic_steal_req = !vic_steal_req;
      reset = ($urandom_range(0, 49) == 0);
      cyc(1);
    end
    reset = 1'b0;
    vic_steal_req = 1'b0;
    set_cpu(16'h0400, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1);

    // Reset while in STEAL.
    align1();
    vic_steal_req = 1'b1;
    cyc(1);
    for (int i = 0; i < 2 * BA_LEAD + 1; i++)
      cyc(1);
    chk("pre_rst_ba", {15'd0, ba}, 16'd0);
    set_cpu(16'h0060, 8'h5A, 1'b1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    vic_steal_req = 1'b0;
    chk("mr_ba", {15'd0, ba}, 16'd1);
    chk("mr_rdy", {15'd0, cpu_rdy}, 16'd1);
    chk("mr_we", {15'd0, ram_we}, 16'd0);
    chk("mr_ce", {15'd0, cpu_ce}, 16'd0);
    chk("mr_mem", {8'd0, mem[16'h0060]}, 16'h0060);
    cyc(1);
    chk("mr_slot", {15'd0, cpu_ce}, 16'd1);
    cyc(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
